cb_config_sequencer: RTL and testbench

Configuration-bus write sequencer that sits directly upstream of the connection box (cb) and drives its `config_addr` / `config_data` / `config_en` port. It accepts configuration writes through a valid/ready request port and buffers them in a small FIFO. It issues each write to the cb as a single-cycle `config_en` pulse and, when requested, reads the written register back through the cb's `read_data` and flags mismatches. Throughput is one write per cycle for unverified writes.

---
 rtl/cb_config_sequencer_if.sv | 26 ++
 rtl/cb_config_sequencer.sv | 137 +++++++++++++
 tb/tb_cb_config_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cb_config_sequencer_if.sv
// Request and connection-box configuration signals of the config-write sequencer.
// master: upstream requester plus cb; slave: the sequencer.
interface cb_config_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_verify;
  logic [ADDR_W-1:0] config_addr;
  logic [DATA_W-1:0] config_data;
  logic              config_en;
  logic [DATA_W-1:0] read_data;

  modport master (
    output req_valid, req_addr, req_data, req_verify, read_data,
    input  req_ready, config_addr, config_data, config_en
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_verify, read_data,
    output req_ready, config_addr, config_data, config_en
  );
endinterface

// File: rtl/cb_config_sequencer.sv
// Buffers config writes in a small FIFO, issues them to the cb as one-cycle
// config_en pulses and optionally reads each one back, flagging mismatches.
module cb_config_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  cb_config_sequencer_if.slave  bus,
  input  logic                  clr_err,
  output logic                  busy,
  output logic                  err,
  output logic [ADDR_W-1:0]     err_addr,
  output logic [7:0]            err_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_FILL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
  logic [DATA_W-1:0] r_fifo_data [DEPTH];
  logic [DEPTH-1:0]  r_fifo_vfy;
  logic [PTR_W:0]    r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]    w_fill, w_fill_nxt;
  logic              w_full, w_empty, w_push, w_pop, w_mismatch;

  logic [ADDR_W-1:0] r_cfg_addr;
  logic [DATA_W-1:0] r_cfg_data;
  logic              r_cfg_en;
  logic              r_cur_vfy;
  logic              r_busy;
  logic              r_err;
  logic [ADDR_W-1:0] r_err_addr;
  logic [7:0]        r_err_cnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_fill     = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_fill == FULL_FILL);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_push     = bus.req_valid && bus.req_ready;
  assign w_fill_nxt = w_fill + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
  // Readback only feeds the error registers, never an output directly.
  assign w_mismatch = (r_state == S_READ) && (bus.read_data != r_cfg_data);

  assign bus.req_ready   = reset && !w_full;
  assign bus.config_addr = r_cfg_addr;
  assign bus.config_data = r_cfg_data;
  assign bus.config_en   = r_cfg_en;
  assign busy            = r_busy;
  assign err             = r_err;
  assign err_addr        = r_err_addr;
  assign err_count       = r_err_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (r_cur_vfy) begin
          w_state_nxt = S_READ;
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
      r_busy <= (w_fill_nxt != '0) || (w_state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr[PTR_W-1:0]] <= bus.req_addr;
      r_fifo_data[r_wr_ptr[PTR_W-1:0]] <= bus.req_data;
      r_fifo_vfy[r_wr_ptr[PTR_W-1:0]]  <= bus.req_verify;
    end
  end

  // Launch stage: a pop loads the cb port and raises config_en for one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cfg_en   <= 1'b0;
      r_cfg_addr <= '0;
      r_cfg_data <= '0;
      r_cur_vfy  <= 1'b0;
    end else begin
      r_cfg_en <= w_pop;
      if (w_pop) begin
        r_cfg_addr <= r_fifo_addr[r_rd_ptr[PTR_W-1:0]];
        r_cfg_data <= r_fifo_data[r_rd_ptr[PTR_W-1:0]];
        r_cur_vfy  <= r_fifo_vfy[r_rd_ptr[PTR_W-1:0]];
      end
    end
  end

  // Compare stage: clr_err wins over a mismatch landing on the same edge.
  always_ff @(posedge clk) begin
    if (!reset || clr_err) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_err_cnt  <= 8'd0;
    end else if (w_mismatch) begin
      r_err     <= 1'b1;
      r_err_cnt <= sat_inc8(r_err_cnt);
      if (!r_err) r_err_addr <= r_cfg_addr;
    end
  end
endmodule

// File: tb/tb_cb_config_sequencer.sv
// Bench for cb_config_sequencer: directed scenarios plus randomized traffic,
// checked against a queue-based model of accepted writes and error bookkeeping.
module tb_cb_config_sequencer;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              vfy;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              clr_err = 1'b0;
  logic              busy, err;
  logic [ADDR_W-1:0] err_addr;
  logic [7:0]        err_count;

  cb_config_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  cb_config_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus), .clr_err(clr_err),
    .busy(busy), .err(err), .err_addr(err_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tmo = 0;
  int stall = 0;
  int mon_bad = 0;
  int cyc = 0;
  bit mon_on = 1'b0;

  // cb register file: captures on config_en, reads back combinationally
  logic [DATA_W-1:0] cb_mem [16];
  logic              force_en = 1'b0;
  logic [DATA_W-1:0] force_val = '0;
  logic              corrupt = 1'b0;

  always @(posedge clk) if (bus.config_en === 1'b1) cb_mem[bus.config_addr[3:0]] <= bus.config_data;
  assign bus.read_data = force_en ? force_val
                       : (cb_mem[bus.config_addr[3:0]] ^ (corrupt ? 32'h0000_0100 : 32'h0));

  // Reference model: pending writes in order, one compare the cycle after a verified write
  wr_t               m_q[$];
  wr_t               m_hold;
  wr_t               m_e;
  bit                m_cmp = 1'b0;
  bit                cmp_now, mism;
  bit                m_err = 1'b0;
  logic [ADDR_W-1:0] m_eaddr = '0;
  int                m_ecnt = 0;
  wr_t               issued[$];
  int                issue_cyc[$];
  wr_t               sent[$];

  always @(negedge clk) begin
    cyc++;
    cmp_now = m_cmp;
    mism = 1'b0;
    if (mon_on && (busy !== ((m_q.size() != 0) || cmp_now))) mon_bad++;
    m_cmp = 1'b0;
    if (bus.config_en === 1'b1) begin
      issued.push_back('{addr: bus.config_addr, data: bus.config_data, vfy: 1'b0});
      issue_cyc.push_back(cyc);
      if (cmp_now || m_q.size() == 0) mon_bad++;
      else begin
        m_e = m_q.pop_front();
        if (m_e.addr !== bus.config_addr || m_e.data !== bus.config_data) mon_bad++;
        m_hold = m_e;
        m_cmp = m_e.vfy;
      end
    end
    if (mon_on && (bus.req_ready !== (reset && (m_q.size() < DEPTH)))) mon_bad++;
    if (reset && bus.req_valid && bus.req_ready)
      m_q.push_back('{addr: bus.req_addr, data: bus.req_data, vfy: bus.req_verify});
    if (cmp_now) mism = (bus.read_data !== m_hold.data);
    if (!reset) begin
      m_q.delete();
      m_cmp = 1'b0;
      m_err = 1'b0; m_ecnt = 0; m_eaddr = '0;
    end else if (clr_err) begin
      m_err = 1'b0; m_ecnt = 0; m_eaddr = '0;
    end else if (mism) begin
      if (!m_err) m_eaddr = m_hold.addr;
      m_err = 1'b1;
      if (m_ecnt < 255) m_ecnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic v, input bit keep, output bit ok);
    bus.req_addr = a; bus.req_data = d; bus.req_verify = v; bus.req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = (bus.req_ready === 1'b1);
      if (!ok) stall++;
      @(posedge clk); #1;
    end
    if (ok) sent.push_back('{addr: a, data: d, vfy: v});
    else tmo++;
    if (!ok || !keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      ok = (busy === 1'b0);
    end
    if (!ok) tmo++;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.config_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", bus.config_en); end
    checks++; if (bus.config_addr !== '0) begin errors++; $display("FAIL rst_addr got %h exp 0", bus.config_addr); end
    checks++; if (bus.config_data !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", bus.config_data); end
    checks++; if (err !== 1'b0 || err_addr !== '0 || err_count !== 8'd0) begin
      errors++; $display("FAIL rst_err got %b/%h/%0d exp 0/0/0", err, err_addr, err_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", bus.req_ready); end
    mon_on = 1'b1;
    #1 reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %b exp 1", bus.req_ready); end
    tick();
  endtask

  task automatic test_single();
    int n0 = issued.size();
    int b = 0;
    int t0 = tmo;
    bit ok;
    push(32'h0, 32'h1, 1'b1, 1'b0, ok);
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (busy === 1'b1) b++; end
    checks++; if (issued.size() - n0 !== 1) begin errors++; $display("FAIL single_cnt got %0d exp 1", issued.size() - n0); end
    else begin
      checks++; if (issued[n0].addr !== 32'h0 || issued[n0].data !== 32'h1) begin
        errors++; $display("FAIL single_word got %h/%h exp 0/1", issued[n0].addr, issued[n0].data); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", err); end
    checks++; if (b !== 3) begin errors++; $display("FAIL single_busy got %0d exp 3 cycles", b); end
    checks++; if (cb_mem[0] !== 32'h1) begin errors++; $display("FAIL single_cb got %h exp 1", cb_mem[0]); end
    checks++; if (tmo !== t0) begin errors++; $display("FAIL single_tmo got %0d exp %0d", tmo, t0); end
    tick();
  endtask

  task automatic test_burst();
    int n0 = issued.size();
    int s0 = stall;
    int mb0 = mon_bad;
    int t0 = tmo;
    int gaps = 0;
    logic [DATA_W-1:0] exp_d [5];
    bit ok;
    exp_d[0] = 32'h1; exp_d[1] = 32'h8; exp_d[2] = 32'h3; exp_d[3] = 32'h5; exp_d[4] = 32'h6;
    push(32'h10, 32'hAA, 1'b1, 1'b1, ok);
    push(32'h11, 32'hBB, 1'b1, 1'b1, ok);
    for (int i = 0; i < 5; i++) push(32'(i + 1), exp_d[i], 1'b0, i != 4, ok);
    wait_idle();
    checks++; if (stall - s0 !== 2) begin errors++; $display("FAIL burst_stall got %0d exp 2", stall - s0); end
    checks++; if (issued.size() - n0 !== 7) begin errors++; $display("FAIL burst_cnt got %0d exp 7", issued.size() - n0); end
    else begin
      for (int i = 0; i < 5; i++) if (issued[n0 + 2 + i].data !== exp_d[i]) gaps++;
      for (int i = 3; i < 7; i++) if (issue_cyc[n0 + i] - issue_cyc[n0 + i - 1] != 1) gaps++;
      checks++; if (gaps !== 0) begin errors++; $display("FAIL burst_order got %0d bad slots exp 0", gaps); end
    end
    checks++; if (mon_bad !== mb0) begin errors++; $display("FAIL burst_model got %0d exp %0d", mon_bad, mb0); end
    checks++; if (tmo !== t0) begin errors++; $display("FAIL burst_tmo got %0d exp %0d", tmo, t0); end
  endtask

  task automatic test_mismatch();
    bit ok;
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    force_en = 1'b1; force_val = 32'h1;
    push(32'h0, 32'h8, 1'b1, 1'b0, ok);
    push(32'h7, 32'h2, 1'b1, 1'b0, ok);
    wait_idle();
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err got %b exp 1", err); end
    checks++; if (err_addr !== 32'h0) begin errors++; $display("FAIL mis_addr got %h exp 0", err_addr); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL mis_cnt got %0d exp 2", err_count); end
    checks++; if (m_ecnt !== 2) begin errors++; $display("FAIL mis_model got %0d exp 2", m_ecnt); end
    force_en = 1'b0;
    tick();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b0 || err_addr !== '0 || err_count !== 8'd0) begin
      errors++; $display("FAIL clr got %b/%h/%0d exp 0/0/0", err, err_addr, err_count); end
    tick();
  endtask

  task automatic test_saturation();
    logic [DATA_W-1:0] d;
    bit ok;
    force_en = 1'b1; force_val = 32'hDEAD_BEEF;
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      if (d == force_val) d = d ^ 32'h1;
      push($urandom, d, 1'b1, 1'b0, ok);
    end
    wait_idle();
    @(negedge clk);
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_cnt got %0d exp 255", err_count); end
    checks++; if (err !== 1'b1 || err_count !== 8'(m_ecnt) || err_addr !== m_eaddr) begin
      errors++; $display("FAIL sat_model got %b/%0d/%h exp 1/%0d/%h", err, err_count, err_addr, m_ecnt, m_eaddr); end
    tick();
    push(32'h5, 32'h1234, 1'b1, 1'b0, ok);
    tick();
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b0 || err_count !== 8'd0) begin
      errors++; $display("FAIL clr_prio got %b/%0d exp 0/0", err, err_count); end
    force_en = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int n0 = issued.size();
    int mb0 = mon_bad;
    bit ok;
    push(32'h20, 32'hA0, 1'b0, 1'b1, ok);
    push(32'h21, 32'hA1, 1'b0, 1'b1, ok);
    push(32'h22, 32'hA2, 1'b0, 1'b0, ok);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.config_en !== 1'b1 || bus.config_data !== 32'hA1) begin
      errors++; $display("FAIL mid_second got %b/%h exp 1/a1", bus.config_en, bus.config_data); end
    @(negedge clk);
    checks++; if (bus.config_en !== 1'b0 || bus.config_addr !== '0 || bus.config_data !== '0) begin
      errors++; $display("FAIL mid_cfg got %b/%h/%h exp 0/0/0", bus.config_en, bus.config_addr, bus.config_data); end
    checks++; if (busy !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL mid_state got busy %b ready %b exp 0/0", busy, bus.req_ready); end
    #1 reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (issued.size() - n0 !== 2) begin errors++; $display("FAIL mid_writes got %0d exp 2", issued.size() - n0); end
    checks++; if (busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_after got busy %b ready %b exp 0/1", busy, bus.req_ready); end
    checks++; if (mon_bad !== mb0) begin errors++; $display("FAIL mid_model got %0d exp %0d", mon_bad, mb0); end
    tick();
  endtask

  task automatic test_random();
    int n0 = issued.size();
    int mb0 = mon_bad;
    int t0 = tmo;
    int bad = 0;
    logic v;
    bit ok;
    sent.delete();
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        bus.req_valid = 1'b0;
        clr_err = 1'b1; tick(); clr_err = 1'b0;
      end
      corrupt = ($urandom_range(0, 2) == 0);
      v = 1'($urandom_range(0, 1));
      push($urandom, $urandom, v, (i != 79) && ($urandom_range(0, 2) != 0), ok);
    end
    wait_idle();
    corrupt = 1'b0;
    @(negedge clk);
    checks++; if (issued.size() - n0 !== sent.size()) begin
      errors++; $display("FAIL rnd_cnt got %0d exp %0d", issued.size() - n0, sent.size()); end
    else begin
      foreach (sent[i]) if (issued[n0 + i].addr !== sent[i].addr || issued[n0 + i].data !== sent[i].data) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL rnd_order got %0d bad exp 0", bad); end
    end
    checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err got %b exp %b", err, m_err); end
    checks++; if (err_count !== 8'(m_ecnt)) begin errors++; $display("FAIL rnd_cnt8 got %0d exp %0d", err_count, m_ecnt); end
    checks++; if (err_addr !== m_eaddr) begin errors++; $display("FAIL rnd_eaddr got %h exp %h", err_addr, m_eaddr); end
    checks++; if (mon_bad !== mb0) begin errors++; $display("FAIL rnd_model got %0d exp %0d", mon_bad, mb0); end
    checks++; if (tmo !== t0) begin errors++; $display("FAIL rnd_tmo got %0d exp %0d", tmo, t0); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_data = '0; bus.req_verify = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_mismatch();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
